// File: rtl/dequant_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dequant_pkg
// Purpose  : Shared sizing constants for the dequantizer slice: lane count,
//            quantized/expanded widths, scale fraction bits, the reset
//            scale value and the internal datapath slice widths.
// Revision : 1.0  initial release
// ============================================================================
package dequant_pkg;

  localparam int LANES = 4;   // lanes packed on each bus
  localparam int QW    = 8;   // quantized lane width (unsigned)
  localparam int PW    = 24;  // expanded lane width (signed)
  localparam int SHIFT = 4;   // fractional bits of the scale

  // Zero-point-corrected difference: {1'b0,q} - {1'b0,zp}, range -255..255.
  localparam int C_DW = QW + 1;
  // Product width. 17 bits hold every result; one extra bit lets the
  // unsigned scale be zero-extended into a signed operand of equal width.
  localparam int C_MW = 2 * QW + 2;

  // Scale of 1.0 in SHIFT-fraction fixed point.
  localparam logic [QW-1:0] C_SCALE_ONE = QW'(16);

endpackage : dequant_pkg
`default_nettype wire

// File: rtl/dequant_if.sv
`default_nettype none
// ============================================================================
// Module   : dequant_if
// Purpose  : Streaming handshake bundle around the dequantizer.
//   dv_qin     per-lane input valid        qin        packed quantized lanes
//   qin_ready  input beat accepted         dv_pout    per-lane output valid
//   pout       packed expanded lanes       pout_ready downstream accepts beat
// Modports : slave  - the dequantizer itself
//            master - the upstream producer / downstream consumer side
// Revision : 1.0  initial release
// ============================================================================
interface dequant_if;
  import dequant_pkg::*;

  logic [LANES-1:0]    dv_qin;
  logic [LANES*QW-1:0] qin;
  logic                qin_ready;
  logic [LANES-1:0]    dv_pout;
  logic [LANES*PW-1:0] pout;
  logic                pout_ready;

  modport slave (
    input  dv_qin, qin, pout_ready,
    output qin_ready, dv_pout, pout
  );

  modport master (
    output dv_qin, qin, pout_ready,
    input  qin_ready, dv_pout, pout
  );

endinterface : dequant_if
`default_nettype wire

// File: rtl/dequant_lane.sv
`default_nettype none
// ============================================================================
// Module   : dequant_lane
// Purpose  : One lane of the two-stage dequantizer datapath.
//            Stage 1 registers q - zp; stage 2 multiplies by the scale that
//            travelled with the beat, rounds half up and sign-extends.
// Ports    : clk, rst (async, active-low)
//            i_adv       pipeline advance enable
//            i_dv, i_q   lane valid / quantized value at the input
//            i_zp        current zero point
//            i_s1_scale  scale captured alongside this lane's stage-1 data
//            o_dv, o_p   lane valid / expanded value at the output
// Revision : 1.0  initial release
// ============================================================================
module dequant_lane
  import dequant_pkg::*;
(
  input  wire logic          clk,
  input  wire logic          rst,
  input  wire logic          i_adv,
  input  wire logic          i_dv,
  input  wire logic [QW-1:0] i_q,
  input  wire logic [QW-1:0] i_zp,
  input  wire logic [QW-1:0] i_s1_scale,
  output logic               o_dv,
  output logic [PW-1:0]      o_p
);

  localparam logic signed [C_MW-1:0] C_RND = C_MW'(2 ** (SHIFT - 1));

  logic                   r_s1_dv;
  logic [C_DW-1:0]        r_s1_d;
  logic                   r_dv;
  logic [PW-1:0]          r_p;

  logic [C_DW-1:0]        w_d;
  logic signed [C_MW-1:0] w_a;
  logic signed [C_MW-1:0] w_b;
  logic signed [C_MW-1:0] w_prod;
  logic signed [C_MW-1:0] w_rnd;
  logic signed [C_MW-1:0] w_shr;
  logic [PW-1:0]          w_ext;

  assign w_d    = {1'b0, i_q} - {1'b0, i_zp};
  // Equal-width signed operands keep the multiply free of implicit extension.
  assign w_a    = {{(C_MW-C_DW){r_s1_d[C_DW-1]}}, r_s1_d};
  assign w_b    = {{(C_MW-QW){1'b0}}, i_s1_scale};
  assign w_prod = w_a * w_b;
  // Adding half an LSB then shifting arithmetically rounds half toward +inf.
  assign w_rnd  = w_prod + C_RND;
  assign w_shr  = w_rnd >>> SHIFT;
  assign w_ext  = {{(PW-C_MW){w_shr[C_MW-1]}}, w_shr};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_dv <= 1'b0;
      r_s1_d  <= '0;
      r_dv    <= 1'b0;
      r_p     <= '0;
    end else if (i_adv) begin
      r_s1_dv <= i_dv;
      r_s1_d  <= w_d;
      r_dv    <= r_s1_dv;
      r_p     <= r_s1_dv ? w_ext : '0;
    end
  end

  assign o_dv = r_dv;
  assign o_p  = r_p;

endmodule : dequant_lane
`default_nettype wire

// File: rtl/dequant.sv
`default_nettype none
// ============================================================================
// Module   : dequant
// Purpose  : Four-lane dequantizer, pout = round((qin - zp) * scale / 2^SHIFT),
//            two-stage pipeline with per-lane valids and a global stall.
// Ports    : clk        rising-edge clock
//            rst        asynchronous active-low reset
//            cfg_we     load cfg_scale / cfg_zp at this edge
//            cfg_scale  unsigned scale, SHIFT fraction bits
//            cfg_zp     unsigned zero point
//            bus        dequant_if.slave (qin/dv_qin/qin_ready in,
//                       pout/dv_pout/pout_ready out)
//            beat_cnt   wrapping count of consumed output beats
// Revision : 1.0  initial release
// ============================================================================
module dequant
  import dequant_pkg::*;
(
  input  wire logic          clk,
  input  wire logic          rst,
  input  wire logic          cfg_we,
  input  wire logic [QW-1:0] cfg_scale,
  input  wire logic [QW-1:0] cfg_zp,
  dequant_if.slave           bus,
  output logic [15:0]        beat_cnt
);

  logic [QW-1:0]       r_scale;
  logic [QW-1:0]       r_zp;
  logic [QW-1:0]       r_s1_scale;
  logic [15:0]         r_beat_cnt;

  logic                w_adv;
  logic                w_consume;
  logic [LANES-1:0]    w_dv_pout;
  logic [LANES*PW-1:0] w_pout;

  // The whole pipe moves together: it advances whenever the output register
  // is empty or being drained, otherwise every stage holds.
  assign w_adv     = (w_dv_pout == '0) | bus.pout_ready;
  assign w_consume = (|w_dv_pout) & bus.pout_ready;

  assign bus.qin_ready = w_adv;
  assign bus.dv_pout   = w_dv_pout;
  assign bus.pout      = w_pout;
  assign beat_cnt      = r_beat_cnt;

  // Config loads even during a stall; beats entering stage 1 on the same
  // edge still see the previous values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_scale <= C_SCALE_ONE;
      r_zp    <= '0;
    end else if (cfg_we) begin
      r_scale <= cfg_scale;
      r_zp    <= cfg_zp;
    end
  end

  // Scale rides with the beat so later writes never touch in-flight data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_scale <= '0;
    end else if (w_adv) begin
      r_s1_scale <= r_scale;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_beat_cnt <= '0;
    end else if (w_consume) begin
      r_beat_cnt <= r_beat_cnt + 16'd1;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    dequant_lane u_lane (
      .clk        (clk),
      .rst        (rst),
      .i_adv      (w_adv),
      .i_dv       (bus.dv_qin[i]),
      .i_q        (bus.qin[QW*i +: QW]),
      .i_zp       (r_zp),
      .i_s1_scale (r_s1_scale),
      .o_dv       (w_dv_pout[i]),
      .o_p        (w_pout[PW*i +: PW])
    );
  end

endmodule : dequant
`default_nettype wire

// File: tb/tb_dequant.sv
`default_nettype none
// ============================================================================
// Module   : tb_dequant
// Purpose  : Directed self-checking bench for dequant. Each accepted beat
//            pushes its expected output to a scoreboard queue; a monitor pops
//            and compares whenever an output beat is consumed.
// Revision : 1.0  initial release
// ============================================================================
module tb_dequant;
  import dequant_pkg::*;

  typedef struct packed {
    logic [LANES-1:0]    dv;
    logic [LANES*PW-1:0] p;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_we;
  logic [QW-1:0] cfg_scale;
  logic [QW-1:0] cfg_zp;
  logic [15:0]   beat_cnt;

  always #5 clk = ~clk;

  dequant_if bus ();

  dequant u_dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_scale (cfg_scale),
    .cfg_zp    (cfg_zp),
    .bus       (bus),
    .beat_cnt  (beat_cnt)
  );

  int       total = 0;
  int       bad   = 0;
  logic [7:0] m_scale = 8'd16;
  logic [7:0] m_zp    = 8'd0;
  exp_t     exp_q[$];
  exp_t     mon_e;
  exp_t     hold_e;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: exact integer arithmetic, rounding half toward +infinity.
  function automatic logic [23:0] model(input logic [7:0] q, input logic [7:0] sc,
                                        input logic [7:0] zp);
    int v, num, r;
    v   = (int'(q) - int'(zp)) * int'(sc);
    num = v + 8;
    if (num >= 0) r = num / 16;
    else          r = -((-num + 15) / 16);
    return r[23:0];
  endfunction

  function automatic exp_t mk_exp(input logic [3:0] dv, input logic [31:0] q,
                                  input logic [7:0] sc, input logic [7:0] zp);
    exp_t e;
    e.dv = dv;
    e.p  = '0;
    for (int i = 0; i < LANES; i++)
      if (dv[i]) e.p[24*i +: 24] = model(q[8*i +: 8], sc, zp);
    return e;
  endfunction

  // Starts and ends on a falling edge; optional config write rides on the
  // first cycle of the beat.
  task automatic send(input logic [3:0] dv, input logic [31:0] q, input logic we,
                      input logic [7:0] sc, input logic [7:0] zp);
    logic ok;
    ok = 1'b0;
    exp_q.push_back(mk_exp(dv, q, m_scale, m_zp));
    bus.dv_qin = dv;
    bus.qin    = q;
    cfg_we     = we;
    cfg_scale  = sc;
    cfg_zp     = zp;
    for (int k = 0; k < 20 && !ok; k++) begin
      #1 ok = bus.qin_ready;
      @(negedge clk);
      cfg_we = 1'b0;
    end
    if (we) begin
      m_scale = sc;
      m_zp    = zp;
    end
    bus.dv_qin = '0;
    chk("accept", 128'(ok), 128'(1'b1));
  endtask

  task automatic idle(input int n);
    bus.dv_qin = '0;
    repeat (n) @(negedge clk);
  endtask

  task automatic set_cfg(input logic [7:0] sc, input logic [7:0] zp);
    cfg_we = 1'b1; cfg_scale = sc; cfg_zp = zp;
    @(negedge clk);
    cfg_we = 1'b0;
    m_scale = sc; m_zp = zp;
  endtask

  // Scoreboard monitor: compares each beat the downstream consumes.
  always @(negedge clk) begin
    #2;
    if (rst === 1'b1 && bus.dv_pout !== '0 && bus.pout_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", 128'(bus.dv_pout), 128'(0));
      end else begin
        mon_e = exp_q.pop_front();
        chk("beat_dv", 128'(bus.dv_pout), 128'(mon_e.dv));
        chk("beat_data", 128'(bus.pout), 128'(mon_e.p));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; cfg_we = 1'b0; cfg_scale = '0; cfg_zp = '0;
    bus.dv_qin = '0; bus.qin = '0; bus.pout_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_dv", 128'(bus.dv_pout), 128'(0));
    chk("rst_pout", 128'(bus.pout), 128'(0));
    chk("rst_cnt", 128'(beat_cnt), 128'(0));
    chk("rst_ready", 128'(bus.qin_ready), 128'(1));
    @(negedge clk);
    rst = 1'b1;

    // Reset scale/zero point: identity.
    send(4'hF, {8'd30, 8'd30, 8'd30, 8'd30}, 1'b0, 8'd0, 8'd0);
    #1 chk("lat_early", 128'(bus.dv_pout), 128'(0));
    @(negedge clk);
    #1 chk("lat_two", 128'(bus.dv_pout), 128'(4'hF));
    idle(3);
    chk("cnt_t1", 128'(beat_cnt), 128'(1));

    // Scale 2.0, zero point 10; lane 3 goes negative.
    set_cfg(8'd32, 8'd10);
    send(4'hF, {8'd0, 8'd10, 8'd200, 8'd100}, 1'b0, 8'd0, 8'd0);
    idle(3);

    // Extreme negative product and zero.
    set_cfg(8'd255, 8'd255);
    send(4'hF, {8'd255, 8'd0, 8'd255, 8'd0}, 1'b0, 8'd0, 8'd0);
    idle(3);
    chk("cnt_t3", 128'(beat_cnt), 128'(3));

    // Backpressure: stall with beat 1 at the output and beat 2 in stage 1.
    set_cfg(8'd16, 8'd0);
    hold_e = mk_exp(4'hF, {8'd4, 8'd3, 8'd2, 8'd1}, m_scale, m_zp);
    send(4'hF, {8'd4, 8'd3, 8'd2, 8'd1}, 1'b0, 8'd0, 8'd0);
    send(4'hF, {8'd80, 8'd70, 8'd60, 8'd50}, 1'b0, 8'd0, 8'd0);
    bus.pout_ready = 1'b0;
    #1;
    chk("bp_ready0", 128'(bus.qin_ready), 128'(0));
    chk("bp_dv0", 128'(bus.dv_pout), 128'(hold_e.dv));
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("bp_ready", 128'(bus.qin_ready), 128'(0));
      chk("bp_hold", 128'(bus.pout), 128'(hold_e.p));
    end
    @(negedge clk);
    bus.pout_ready = 1'b1;
    send(4'hF, {8'd9, 8'd17, 8'd128, 8'd255}, 1'b0, 8'd0, 8'd0);
    idle(4);
    chk("cnt_bp", 128'(beat_cnt), 128'(6));

    // Config write alongside a partial-lane beat: that beat keeps 16/0.
    send(4'b0101, {8'd99, 8'd60, 8'd99, 8'd40}, 1'b1, 8'd48, 8'd5);
    send(4'hF, {8'd40, 8'd40, 8'd40, 8'd40}, 1'b0, 8'd0, 8'd0);
    idle(4);
    chk("cnt_cfg", 128'(beat_cnt), 128'(8));

    // Asynchronous reset with two beats in flight.
    send(4'hF, {8'd11, 8'd22, 8'd33, 8'd44}, 1'b0, 8'd0, 8'd0);
    send(4'hF, {8'd55, 8'd66, 8'd77, 8'd88}, 1'b0, 8'd0, 8'd0);
    #1 rst = 1'b0;
    #1;
    chk("arst_dv", 128'(bus.dv_pout), 128'(0));
    chk("arst_pout", 128'(bus.pout), 128'(0));
    chk("arst_cnt", 128'(beat_cnt), 128'(0));
    exp_q.delete();
    m_scale = 8'd16;
    m_zp    = 8'd0;
    @(negedge clk);
    rst = 1'b1;
    idle(5);
    chk("post_rst_cnt", 128'(beat_cnt), 128'(0));
    send(4'hF, {8'd30, 8'd30, 8'd30, 8'd30}, 1'b0, 8'd0, 8'd0);
    idle(4);
    chk("post_rst_cnt1", 128'(beat_cnt), 128'(1));
    chk("drain", 128'(exp_q.size()), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_dequant
`default_nettype wire
